// File: rtl/i2c_eeprom_slave.sv
// I2C responder modelling a byte-addressed serial EEPROM: oversampled SCL/SDA,
// byte/page write, current-address, random and sequential read.
module i2c_eeprom_slave #(
   parameter logic [6:0] DEV_ADDR = 7'h50,
   parameter int         ADDR_W   = 8,
   parameter int         PAGE_W   = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              scl_i,
   input  logic              sda_i,
   output logic              sda_s2m,
   output logic              busy,
   output logic              wr_stb,
   output logic [ADDR_W-1:0] wr_addr
);

   typedef enum logic [3:0] {
      IDLE, DEV, DEV_ACK, WADDR, WADDR_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK, IGNORE
   } state_t;

   // [0],[1] synchronizer stages, [2] history for edge/condition detection
   logic [2:0] scl_sh, sda_sh;
   logic       scl_s, scl_h, sda_s, sda_h;
   logic       scl_rise, scl_fall, start_c, stop_c;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scl_sh <= 3'b111;
         sda_sh <= 3'b111;
      end else begin
         scl_sh <= {scl_sh[1:0], scl_i};
         sda_sh <= {sda_sh[1:0], sda_i};
      end
   end

   assign scl_s    = scl_sh[1];
   assign scl_h    = scl_sh[2];
   assign sda_s    = sda_sh[1];
   assign sda_h    = sda_sh[2];
   assign scl_rise =  scl_s & ~scl_h;
   assign scl_fall = ~scl_s &  scl_h;
   // SCL must be stable high across both samples, so an SCL edge always wins
   assign start_c  = scl_s & scl_h &  sda_h & ~sda_s;
   assign stop_c   = scl_s & scl_h & ~sda_h &  sda_s;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [7:0]        shreg_q, shreg_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              rw_q, rw_d;
   logic              sda_q, sda_d;
   logic              busy_q, busy_d;
   logic              wr_stb_q, wr_stb_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

   logic [7:0]        mem [0:2**ADDR_W-1];
   logic              mem_we;
   logic [7:0]        rx_byte, rd_byte;
   logic [ADDR_W-1:0] page_inc;

   assign rx_byte = {shreg_q[6:0], sda_s};
   assign rd_byte = mem[ptr_q];

   // write pointer only rolls inside its page
   always_comb begin
      page_inc = ptr_q;
      page_inc[PAGE_W-1:0] = ptr_q[PAGE_W-1:0] + PAGE_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         shreg_q   <= '0;
         ptr_q     <= '0;
         rw_q      <= 1'b0;
         sda_q     <= 1'b1;
         busy_q    <= 1'b0;
         wr_stb_q  <= 1'b0;
         wr_addr_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shreg_q   <= shreg_d;
         ptr_q     <= ptr_d;
         rw_q      <= rw_d;
         sda_q     <= sda_d;
         busy_q    <= busy_d;
         wr_stb_q  <= wr_stb_d;
         wr_addr_q <= wr_addr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[ptr_q] <= rx_byte;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shreg_d   = shreg_q;
      ptr_d     = ptr_q;
      rw_d      = rw_q;
      sda_d     = sda_q;
      busy_d    = busy_q;
      wr_stb_d  = 1'b0;
      wr_addr_d = wr_addr_q;
      mem_we    = 1'b0;

      if (start_c) begin
         state_d = DEV;
         cnt_d   = '0;
         sda_d   = 1'b1;
      end else if (stop_c) begin
         state_d = IDLE;
         cnt_d   = '0;
         sda_d   = 1'b1;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: ;
            DEV: if (scl_rise) begin
               shreg_d = rx_byte;
               cnt_d   = cnt_q + 4'd1;
               if (cnt_q == 4'd7) begin
                  cnt_d = '0;
                  rw_d  = sda_s;
                  if (rx_byte[7:1] == DEV_ADDR) begin
                     state_d = DEV_ACK;
                     busy_d  = 1'b1;
                  end else begin
                     state_d = IGNORE;
                     busy_d  = 1'b0;
                  end
               end
            end
            // cnt 0: pull low on the fall after bit 8; cnt 1: release on the 9th fall
            DEV_ACK, WADDR_ACK, WDATA_ACK: if (scl_fall) begin
               if (cnt_q == 4'd0) begin
                  sda_d = 1'b0;
                  cnt_d = 4'd1;
               end else begin
                  sda_d = 1'b1;
                  cnt_d = '0;
                  if (state_q == DEV_ACK && rw_q) begin
                     state_d = RDATA;
                     sda_d   = rd_byte[7];
                     shreg_d = {rd_byte[6:0], 1'b0};
                  end else if (state_q == DEV_ACK) begin
                     state_d = WADDR;
                  end else begin
                     state_d = WDATA;
                  end
               end
            end
            WADDR: if (scl_rise) begin
               shreg_d = rx_byte;
               cnt_d   = cnt_q + 4'd1;
               if (cnt_q == 4'd7) begin
                  cnt_d   = '0;
                  ptr_d   = ADDR_W'(rx_byte);
                  state_d = WADDR_ACK;
               end
            end
            WDATA: if (scl_rise) begin
               shreg_d = rx_byte;
               cnt_d   = cnt_q + 4'd1;
               if (cnt_q == 4'd7) begin
                  cnt_d     = '0;
                  mem_we    = 1'b1;
                  wr_stb_d  = 1'b1;
                  wr_addr_d = ptr_q;
                  ptr_d     = page_inc;
                  state_d   = WDATA_ACK;
               end
            end
            // rises count bits the master has taken; falls present the next bit
            RDATA: begin
               if (scl_rise) begin
                  cnt_d = cnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (cnt_q == 4'd8) begin
                     sda_d   = 1'b1;
                     cnt_d   = '0;
                     ptr_d   = ptr_q + ADDR_W'(1);
                     state_d = RD_MACK;
                  end else begin
                     sda_d   = shreg_q[7];
                     shreg_d = {shreg_q[6:0], 1'b0};
                  end
               end
            end
            RD_MACK: if (scl_rise) begin
               if (!sda_s) begin
                  shreg_d = rd_byte;
                  cnt_d   = '0;
                  state_d = RDATA;
               end else begin
                  sda_d   = 1'b1;
                  busy_d  = 1'b0;
                  state_d = IGNORE;
               end
            end
            IGNORE: sda_d = 1'b1;
            default: state_d = IDLE;
         endcase
      end
   end

   assign sda_s2m = sda_q;
   assign busy    = busy_q;
   assign wr_stb  = wr_stb_q;
   assign wr_addr = wr_addr_q;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Directed bench for i2c_eeprom_slave: bit-banged I2C master, write table,
// read-back, page/read wrap, wrong address, STOP abort and reset abort.
module tb_i2c_eeprom_slave;

   localparam int Q = 8;   // clk cycles per quarter SCL period

   logic       clk = 1'b0;
   logic       reset;
   logic       scl_i, sda_i;
   logic       sda_s2m, busy, wr_stb;
   logic [7:0] wr_addr;

   always #5 clk = ~clk;

   i2c_eeprom_slave #(.DEV_ADDR(7'h50), .ADDR_W(8), .PAGE_W(3)) dut (
      .clk     (clk),
      .reset   (reset),
      .scl_i   (scl_i),
      .sda_i   (sda_i),
      .sda_s2m (sda_s2m),
      .busy    (busy),
      .wr_stb  (wr_stb),
      .wr_addr (wr_addr)
   );

   int         n_cmp = 0;
   int         n_bad = 0;
   int         low_cnt = 0;
   logic [7:0] wr_log [$];

   always @(negedge clk) begin
      if (wr_stb) wr_log.push_back(wr_addr);
      if (!sda_s2m) low_cnt++;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic i2c_start();
      sda_i = 1'b1; tick(Q);
      scl_i = 1'b1; tick(Q);
      sda_i = 1'b0; tick(Q);
      scl_i = 1'b0; tick(Q);
   endtask

   task automatic i2c_stop();
      sda_i = 1'b0; tick(Q);
      scl_i = 1'b1; tick(Q);
      sda_i = 1'b1; tick(Q);
   endtask

   task automatic send_bit(input logic b);
      sda_i = b;    tick(Q);
      scl_i = 1'b1; tick(2*Q);
      scl_i = 1'b0; tick(Q);
   endtask

   task automatic recv_bit(output logic b);
      sda_i = 1'b1; tick(Q);
      scl_i = 1'b1; tick(Q);
      b = sda_s2m;  tick(Q);
      scl_i = 1'b0; tick(Q);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      recv_bit(ack);
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] d);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         recv_bit(b);
         d[i] = b;
      end
      send_bit(mack);
   endtask

   task automatic rand_read(input logic [7:0] a, output logic [7:0] d);
      logic ack;
      i2c_start();
      write_byte(8'hA0, ack); check("rr dev ack", ack, 1'b0);
      write_byte(a, ack);     check("rr addr ack", ack, 1'b0);
      i2c_start();
      write_byte(8'hA1, ack); check("rr rdev ack", ack, 1'b0);
      read_byte(1'b1, d);
      tick(4);
      check("rr released after nack", sda_s2m, 1'b1);
      i2c_stop();
   endtask

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
      logic [7:0] exp_wr_addr;
      logic [7:0] exp_rd;
   } vec_t;

   vec_t       vecs [6];
   logic       ack, b;
   logic [7:0] d;
   int         wl0, lc0;

   initial begin
      vecs[0] = '{8'h12, 8'h5A, 8'h12, 8'h5A};
      vecs[1] = '{8'h13, 8'hC6, 8'h13, 8'hC6};
      vecs[2] = '{8'hFF, 8'hEE, 8'hFF, 8'hEE};
      vecs[3] = '{8'h01, 8'h44, 8'h01, 8'h44};
      vecs[4] = '{8'h30, 8'hC3, 8'h30, 8'hC3};
      vecs[5] = '{8'h40, 8'h0F, 8'h40, 8'h0F};

      reset = 1'b1; scl_i = 1'b1; sda_i = 1'b1;
      tick(3); #1;
      check("reset sda_s2m", sda_s2m, 1'b1);
      check("reset busy", busy, 1'b0);
      check("reset wr_stb", wr_stb, 1'b0);
      check("reset wr_addr", wr_addr, 8'h00);
      reset = 1'b0;
      tick(5);

      // byte writes from the table
      for (int i = 0; i < 6; i++) begin
         wl0 = wr_log.size();
         i2c_start();
         write_byte(8'hA0, ack);        check("bw dev ack", ack, 1'b0);
         check("bw busy", busy, 1'b1);
         write_byte(vecs[i].addr, ack); check("bw addr ack", ack, 1'b0);
         write_byte(vecs[i].data, ack); check("bw data ack", ack, 1'b0);
         i2c_stop();
         tick(5);
         check("bw busy after stop", busy, 1'b0);
         check("bw wr_stb count", wr_log.size(), wl0 + 1);
         if (wr_log.size() > wl0) check("bw wr_addr", wr_log[wl0], vecs[i].exp_wr_addr);
      end

      for (int i = 0; i < 6; i++) begin
         rand_read(vecs[i].addr, d);
         check("rr data", d, vecs[i].exp_rd);
      end

      // random read of 0x12 leaves ptr at 0x13; current-address read follows it
      rand_read(8'h12, d);
      check("rr 0x12", d, 8'h5A);
      i2c_start();
      write_byte(8'hA1, ack); check("cur dev ack", ack, 1'b0);
      read_byte(1'b1, d);
      i2c_stop();
      check("cur read 0x13", d, 8'hC6);

      // page wrap 0x06,0x07,0x00
      wl0 = wr_log.size();
      i2c_start();
      write_byte(8'hA0, ack); check("pw dev ack", ack, 1'b0);
      write_byte(8'h06, ack); check("pw addr ack", ack, 1'b0);
      write_byte(8'h11, ack); check("pw d0 ack", ack, 1'b0);
      write_byte(8'h22, ack); check("pw d1 ack", ack, 1'b0);
      write_byte(8'h33, ack); check("pw d2 ack", ack, 1'b0);
      i2c_stop();
      tick(5);
      check("pw wr_stb count", wr_log.size(), wl0 + 3);
      if (wr_log.size() >= wl0 + 3) begin
         check("pw wr_addr0", wr_log[wl0],   8'h06);
         check("pw wr_addr1", wr_log[wl0+1], 8'h07);
         check("pw wr_addr2", wr_log[wl0+2], 8'h00);
      end
      rand_read(8'h06, d); check("pw mem06", d, 8'h11);
      rand_read(8'h07, d); check("pw mem07", d, 8'h22);
      rand_read(8'h00, d); check("pw mem00", d, 8'h33);

      // sequential read wrapping 0xFF -> 0x00 -> 0x01
      i2c_start();
      write_byte(8'hA0, ack); check("sr dev ack", ack, 1'b0);
      write_byte(8'hFF, ack); check("sr addr ack", ack, 1'b0);
      i2c_start();
      write_byte(8'hA1, ack); check("sr rdev ack", ack, 1'b0);
      read_byte(1'b0, d); check("sr memFF", d, 8'hEE);
      read_byte(1'b0, d); check("sr mem00", d, 8'h33);
      read_byte(1'b1, d); check("sr mem01", d, 8'h44);
      tick(4);
      check("sr released", sda_s2m, 1'b1);
      i2c_stop();
      tick(5);
      check("sr busy", busy, 1'b0);

      // wrong device address: never pulls low, never writes
      wl0 = wr_log.size();
      lc0 = low_cnt;
      i2c_start();
      write_byte(8'hA2, ack); check("wa dev nack", ack, 1'b1);
      check("wa busy", busy, 1'b0);
      write_byte(8'h12, ack); check("wa b1 nack", ack, 1'b1);
      write_byte(8'h99, ack); check("wa b2 nack", ack, 1'b1);
      i2c_stop();
      tick(5);
      check("wa sda low cycles", low_cnt, lc0);
      check("wa wr_stb count", wr_log.size(), wl0);

      // STOP after 4 data bits discards the partial byte
      wl0 = wr_log.size();
      i2c_start();
      write_byte(8'hA0, ack); check("ab dev ack", ack, 1'b0);
      write_byte(8'h30, ack); check("ab addr ack", ack, 1'b0);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      i2c_stop();
      tick(3);
      check("ab sda released", sda_s2m, 1'b1);
      check("ab busy", busy, 1'b0);
      check("ab wr_stb count", wr_log.size(), wl0);
      rand_read(8'h30, d); check("ab mem30 kept", d, 8'hC3);

      // reset while the slave drives read data (0x0F: first four bits are 0)
      i2c_start();
      write_byte(8'hA0, ack); check("rs dev ack", ack, 1'b0);
      write_byte(8'h40, ack); check("rs addr ack", ack, 1'b0);
      i2c_start();
      write_byte(8'hA1, ack); check("rs rdev ack", ack, 1'b0);
      for (int i = 0; i < 3; i++) begin
         recv_bit(b);
         check("rs early bit", b, 1'b0);
      end
      check("rs driving before reset", sda_s2m, 1'b0);
      reset = 1'b1;
      #1;
      check("rs sda after reset", sda_s2m, 1'b1);
      check("rs busy after reset", busy, 1'b0);
      scl_i = 1'b1; sda_i = 1'b1;
      tick(3);
      reset = 1'b0;
      tick(5);
      wl0 = wr_log.size();
      i2c_start();
      write_byte(8'hA0, ack); check("post dev ack", ack, 1'b0);
      write_byte(8'h50, ack); check("post addr ack", ack, 1'b0);
      write_byte(8'h77, ack); check("post data ack", ack, 1'b0);
      i2c_stop();
      tick(5);
      check("post wr_stb count", wr_log.size(), wl0 + 1);
      rand_read(8'h50, d); check("post mem50", d, 8'h77);
      rand_read(8'h12, d); check("post mem12 kept", d, 8'h5A);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/i2c_eeprom_slave.md
Name: i2c_eeprom_slave

Overview:
- Synthesizable I2C responder that models a byte-addressed serial EEPROM on the chip-level I2C pins.
- It is the target for the SoC's I2C master, which drives SCL and SDA (master-to-slave) and samples the slave-to-master SDA return.
- It also serves as a loopback target in the FPGA simulation environment.
- It oversamples SCL/SDA on the system clock, decodes START/STOP/address/data, and supports byte write, page write, current-address read, random read and sequential read.

Parameters:
- DEV_ADDR, 7'h50: 7-bit device address the block answers to.
- ADDR_W, 8: word-address width; the memory holds 2**ADDR_W bytes.
- PAGE_W, 3: log2 of page size; write address wraps inside an 8-byte page.

Ports:
- clk, input, 1: system clock; frequency must be at least 16x SCL.
- reset, input, 1: asynchronous, active-high reset.
- scl_i, input, 1: SCL from the master, asynchronous to clk.
- sda_i, input, 1: SDA from the master (sda_m2s), asynchronous to clk.
- sda_s2m, output, 1: slave SDA return; 0 = pull low, 1 = release (open-drain emulation).
- busy, output, 1: high from an addressed START until STOP or NACK-terminated release.
- wr_stb, output, 1: one-cycle pulse when a data byte is committed to memory.
- wr_addr, output, ADDR_W: address of the committed byte; valid with wr_stb.

Behaviour:
- Interface:
  - One clock, clk.
  - Reset is asynchronous and active-high, port name reset.
  - scl_i and sda_i pass through 2-flop synchronizers plus one history flop; all decoding uses the synchronized values.
- Reset values:
  - sda_s2m = 1, busy = 0, wr_stb = 0, wr_addr = 0.
  - Internal address pointer = 0, FSM = IDLE.
  - Memory contents are not reset.
- Condition detection:
  - START: synchronized SDA falls while SCL is high.
  - STOP: synchronized SDA rises while SCL is high.
  - Data bits are sampled on the SCL rising edge, MSB first.
  - The slave changes sda_s2m only on the SCL falling edge.
  - sda_s2m latency: 3 clk after the pin-level SCL fall (2 sync + 1 register).
- FSM states: IDLE, DEV, DEV_ACK, WADDR, WADDR_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK, IGNORE.
  - IDLE: on START, go to DEV and clear the bit counter.
  - DEV: shift 8 bits. If bits[7:1] == DEV_ADDR, go to DEV_ACK; otherwise go to IGNORE.
  - DEV_ACK:
    - Drive 0 from the SCL fall after bit 8 until the SCL fall after the 9th clock; busy = 1.
    - If R/W = 0, go to WADDR.
    - If R/W = 1, load the shift register with mem[ptr] and go to RDATA.
  - WADDR: shift 8 bits; load ptr on the 8th rising edge; then WADDR_ACK (ACK driven), then WDATA.
  - WDATA: shift 8 bits. On the 8th rising edge:
    - mem[ptr] <= byte; wr_stb = 1 for 1 clk; wr_addr = ptr.
    - ptr[PAGE_W-1:0] increments with wrap; upper bits stay unchanged.
    - Then WDATA_ACK (ACK driven), then WDATA.
  - RDATA:
    - Drive the shift-register MSB on each SCL fall; 8 bits.
    - After the 8th bit, release SDA, increment ptr with a full 2**ADDR_W wrap, and go to RD_MACK.
  - RD_MACK: sample the master's bit on the 9th SCL rise.
    - 0 (ACK): load mem[ptr], go to RDATA.
    - 1 (NACK): release SDA, busy = 0, go to IGNORE.
  - IGNORE: sda_s2m = 1; wait for START or STOP.
- Boundary conditions:
  - START in any state (repeated START) aborts the current byte, releases SDA on the next clk, and goes to DEV. Any partial byte is discarded and not written.
  - STOP in any state: go to IDLE, sda_s2m = 1, busy = 0. A partial write byte is discarded.
  - Random read: write phase sets ptr, then repeated START with R = 1 reads from ptr.
  - Write ptr wraps within the page: 0x07 -> 0x00 for base 0x00, 0x17 -> 0x10.
  - Read ptr wraps 0xFF -> 0x00.
  - SDA transitions while SCL is high are only ever decoded as START/STOP, never as data.
  - Simultaneous SCL and SDA change in one synchronized sample: SCL edge takes priority, and no START/STOP is flagged.
  - Reset mid-transfer: everything returns to reset values immediately; memory is retained.

Test Plan:
- Byte write: START, 0xA0, 0x12, 0x5A, STOP -> three ACKs (sda_s2m = 0 on the 9th clocks); wr_stb once with wr_addr = 0x12; mem[0x12] = 0x5A; busy falls at STOP.
- Random read: write 0x12, repeated START, 0xA1, master NACK, STOP -> slave shifts 0x5A MSB-first; SDA released after NACK; ptr = 0x13.
- Page wrap: START, 0xA0, 0x06, then data 0x11, 0x22, 0x33, STOP -> mem[0x06] = 0x11, mem[0x07] = 0x22, mem[0x00] = 0x33; wr_addr sequence 0x06, 0x07, 0x00.
- Sequential read wrap: ptr = 0xFF, START, 0xA1, ACK, ACK, NACK -> data mem[0xFF], mem[0x00], mem[0x01].
- Wrong address: START, 0xA2, ... -> sda_s2m stays 1 for the whole transaction; busy = 0; no wr_stb.
- Abort: STOP after 4 data bits of a write, and separately reset asserted during RDATA -> no memory write; sda_s2m = 1 within 1 clk (reset) or 3 clk of the synchronized STOP; FSM = IDLE; the next transaction is ACKed normally.
